// File: rtl/flex_stp_word_sr.sv
// ---------------------------------------------------------------------------
// flex_stp_word_sr
//
// Serial-to-parallel shift register with word framing for the USB RX
// datapath. Sits between the bit decoder/destuffer and the RX control
// FSM/FIFO. One serial bit is taken per strobed cycle; a stuffed bit can be
// discarded with skip. After NUM_BITS accepted bits the completed word is
// captured into a holding register and offered through a valid/ack
// handshake. A sticky overrun flag records a word overwriting an unconsumed
// one.
//
// Parameters:
//   NUM_BITS   : word width, 2..32
//   SHIFT_MSB  : 1 = bits enter at bit 0 and move toward the MSB
//                0 = bits enter at bit NUM_BITS-1 and move toward the LSB
//                    (USB order, first bit ends up as the LSB)
//   RESET_ONES : 1 = shift register idles at all ones, 0 = all zeros
//
// Ports:
//   clk           in   rising-edge clock
//   n_rst         in   asynchronous active-low reset
//   clear         in   synchronous clear of framing state, highest priority
//   shift_enable  in   serial_in is valid this cycle
//   skip          in   with shift_enable: drop this bit, no shift, no count
//   serial_in     in   serial data bit
//   word_ack      in   consumer has taken word_out
//   parallel_out  out  live shift register contents
//   bit_count     out  bits accepted in the current word, 0..NUM_BITS-1
//   word_out      out  last completed word
//   word_valid    out  word_out holds an unconsumed word
//   overrun       out  sticky: a completed word replaced an unconsumed one
// ---------------------------------------------------------------------------
module flex_stp_word_sr #(
    parameter int NUM_BITS   = 8,
    parameter int SHIFT_MSB  = 0,
    parameter int RESET_ONES = 1
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              clear,
    input  logic                              shift_enable,
    input  logic                              skip,
    input  logic                              serial_in,
    input  logic                              word_ack,
    output logic [NUM_BITS-1:0]               parallel_out,
    output logic [$clog2(NUM_BITS+1)-1:0]     bit_count,
    output logic [NUM_BITS-1:0]               word_out,
    output logic                              word_valid,
    output logic                              overrun
);

    localparam int CNT_W = $clog2(NUM_BITS + 1);

    localparam logic [NUM_BITS-1:0] SR_RESET  = (RESET_ONES != 0) ? '1 : '0;
    localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(NUM_BITS - 1);

    logic                 accept;
    logic                 last_bit;
    logic                 complete;
    logic [NUM_BITS-1:0]  shifted;

    logic [NUM_BITS-1:0]  parallel_next;
    logic [CNT_W-1:0]     count_next;
    logic [NUM_BITS-1:0]  word_next;
    logic                 valid_next;
    logic                 overrun_next;

    // Post-shift value of the register; direction fixed at elaboration.
    generate
        if (SHIFT_MSB != 0) begin : g_shift_msb
            assign shifted = {parallel_out[NUM_BITS-2:0], serial_in};
        end else begin : g_shift_lsb
            assign shifted = {serial_in, parallel_out[NUM_BITS-1:1]};
        end
    endgenerate

    // A bit counts only when strobed, not stuffed, and not being cleared.
    // The word completes on the same edge that accepts its final bit, so
    // word_out is loaded from the post-shift value including that bit.
    assign accept   = shift_enable & ~skip & ~clear;
    assign last_bit = (bit_count == LAST_BIT);
    assign complete = accept & last_bit;

    // Next-state logic. Clear dominates everything but leaves word_out
    // alone so a consumer can still read the last good word. On a
    // completion the valid flag stays set regardless of word_ack; an ack in
    // the same cycle simply means the old word was consumed, so only a
    // completion without ack over a pending word raises overrun.
    always_comb begin
        parallel_next = parallel_out;
        count_next    = bit_count;
        word_next     = word_out;
        valid_next    = word_valid;
        overrun_next  = overrun;

        if (clear) begin
            parallel_next = SR_RESET;
            count_next    = '0;
            valid_next    = 1'b0;
            overrun_next  = 1'b0;
        end else begin
            if (accept) begin
                parallel_next = shifted;
                count_next    = last_bit ? '0 : bit_count + 1'b1;
            end

            if (complete) begin
                word_next  = shifted;
                valid_next = 1'b1;
                if (word_valid && !word_ack) begin
                    overrun_next = 1'b1;
                end
            end else if (word_ack && word_valid) begin
                valid_next = 1'b0;
            end
        end
    end

    // State register; every output comes straight from here.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= SR_RESET;
            bit_count    <= '0;
            word_out     <= '0;
            word_valid   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            parallel_out <= parallel_next;
            bit_count    <= count_next;
            word_out     <= word_next;
            word_valid   <= valid_next;
            overrun      <= overrun_next;
        end
    end

endmodule

// File: doc/flex_stp_word_sr.md
Name: flex_stp_word_sr

Overview:
- Parametrised serial-to-parallel shift register with word framing, for the USB RX datapath.
- Accepts one serial bit per qualified cycle and can discard a bit (bit-stuff removal) without shifting.
- Counts accepted bits and, after NUM_BITS bits, captures a completed word into a holding register with a valid/ack handshake and sticky overrun detection.
- Sits between the RX bit decoder/destuffer and the RX control FSM/FIFO.

Parameters:
- NUM_BITS, 8: word width in bits; legal range 2..32.
- SHIFT_MSB, 0: 1 = new bit enters at bit 0 and shifts toward the MSB (MSB-first); 0 = new bit enters at bit NUM_BITS-1 and shifts toward the LSB (LSB-first, USB order).
- RESET_ONES, 1: 1 = shift register resets to all ones (idle line); 0 = resets to all zeros.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of framing state; priority over all other inputs.
- shift_enable  input  1  bit strobe; serial_in is valid this cycle.
- skip  input  1  with shift_enable, discard the current bit (stuffed bit); no shift, no count.
- serial_in  input  1  serial data bit.
- word_ack  input  1  consumer has taken word_out; clears word_valid.
- parallel_out  output  NUM_BITS  live shift register contents.
- bit_count  output  $clog2(NUM_BITS+1)  number of bits accepted in the current word, 0..NUM_BITS-1.
- word_out  output  NUM_BITS  last completed word (holding register).
- word_valid  output  1  word_out holds an unconsumed word.
- overrun  output  1  sticky; a completed word overwrote an unconsumed one.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - parallel_out = all ones if RESET_ONES=1, else all zeros.
  - bit_count = 0, word_out = 0, word_valid = 0, overrun = 0.
- Accepted bit: accept = shift_enable & ~skip & ~clear.
- Shift on accept:
  - SHIFT_MSB=1: parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in}.
  - SHIFT_MSB=0: parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]}.
- No accept: parallel_out holds. skip without shift_enable has no effect.
- Counting:
  - bit_count increments on accept.
  - When accept and bit_count == NUM_BITS-1, bit_count wraps to 0 and the word completes.
- Word completion, same edge:
  - word_out <= the post-shift value, i.e. it includes the bit accepted this cycle.
  - word_valid <= 1.
  - Latency: word_out is visible the cycle after the edge that samples the last bit.
  - parallel_out is not cleared on completion; it keeps shifting freely into the next word.
- Handshake:
  - word_ack while word_valid=1 and no completion this cycle: word_valid <= 0; word_out holds.
  - word_ack while word_valid=0 is ignored.
- Simultaneous completion and word_ack: word_valid stays 1, word_out takes the new word, no overrun.
- Completion while word_valid=1 and word_ack=0:
  - word_out is overwritten with the new word.
  - word_valid stays 1.
  - overrun <= 1.
- overrun is sticky; only clear or reset returns it to 0.
- clear=1 (synchronous):
  - parallel_out <= reset value, bit_count <= 0, word_valid <= 0, overrun <= 0.
  - word_out holds.
  - shift_enable and word_ack are ignored that cycle.
- Mid-word clear or reset discards the partial bits. The next accepted bit is bit 0 of a new word.
- Single always_ff for state plus always_comb for next state, no latches; all outputs are registered.

Test Plan:
1. Reset check: assert n_rst=0 mid-cycle -> parallel_out=8'hFF, bit_count=0, word_valid=0, overrun=0 immediately, with no clock edge required.
2. LSB-first word: NUM_BITS=8, SHIFT_MSB=0; shift serial 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> after the 8th edge word_out=8'hA5, word_valid=1, bit_count=0. Then word_ack for 1 cycle -> word_valid=0, word_out stays 8'hA5.
3. Bit-stuff skip: same 8-bit stream with a 9th bit inserted after bit 5, presented with skip=1 -> word_out=8'hA5, completes one cycle later than scenario 2, bit_count stalls during the skip.
4. Overrun versus simultaneous ack:
   - Send 8'h3C then 8'hC3 with no ack -> word_out=8'hC3, word_valid=1, overrun=1.
   - Repeat with word_ack asserted on the completion cycle of 8'hC3 -> word_out=8'hC3, word_valid=1, overrun=0.
5. Mid-word clear: shift 5 bits, pulse clear for 1 cycle with shift_enable=1 -> bit_count=0, parallel_out=8'hFF, the bit is not accepted, overrun=0. Then 8 bits of 8'h5A -> word_out=8'h5A.
6. MSB-first variant: NUM_BITS=4, SHIFT_MSB=1, RESET_ONES=0; shift 1,1,0,1 -> word_out=4'hD. Reset applied during bit 2 -> all outputs return to 0 asynchronously.
